// File: rtl/data_memory_arb_pkg.sv
// Shared types and round-robin search helper for data-memory arbitration.
// Latency: combinational helper only.
// Backpressure: none; pure definitions.
package data_memory_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_LOCK_MAX = 16;
    localparam int RR_MAX_REQ       = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid starting at ptr and wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [2:0]            ptr,
        input int                    nreq
    );
        rr_pick_t   r;
        int         j;
        logic [2:0] j3;
        r = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            if (k < nreq) begin
                j = int'(ptr) + k;
                if (j >= nreq) begin
                    j = j - nreq;
                end
                j3 = 3'(j);
                if (!r.found && valid[j3]) begin
                    r.found = 1'b1;
                    r.idx   = j3;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_priority_pick.sv
// Round-robin index select over NREQ request lines, starting at ptr_i.
// Latency: combinational.
// Backpressure: none; caller decides whether the pick is consumed.
module rr_priority_pick
    import data_memory_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            found_o,
    output logic [IW-1:0]   idx_o
);

    logic [RR_MAX_REQ-1:0] valid_ext;
    logic [2:0]            ptr_ext;
    rr_pick_t              pick;
    logic                  unused_idx_bits;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid_i;
        ptr_ext               = '0;
        ptr_ext[IW-1:0]       = ptr_i;
        pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
    end

    assign found_o         = pick.found;
    assign idx_o           = pick.idx[IW-1:0];
    assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter with atomic lock sharing one single-port data memory; optional DATA_MEMORY_ARB_STATS_EN counters.
// Latency: grant and memory drive combinational; load response registered, 1 cycle.
// Backpressure: req_ready low stalls a requester; at most one grant per cycle; locked owner excludes others.
module data_memory_arbiter
    import data_memory_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = DEFAULT_LOCK_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               lock_err,
    output logic [AW-1:0]      mem_adr,
    output logic               mem_read_en,
    output logic               mem_write_en,
    output logic [DW-1:0]      mem_dat_in,
    input  logic [DW-1:0]      mem_dat_out
`ifdef DATA_MEMORY_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            lock_err_q, lock_err_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_we;
    logic            gnt_lock;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Reset masks the grant so memory enables stay low during reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = pick_idx;
        if (!reset) begin
            if (state_q == LOCKED) begin
                gnt_idx = owner_q;
                gnt_vld = req_valid[owner_q];
            end else begin
                gnt_vld = pick_found;
            end
        end
    end

    assign gnt_we   = req_we[gnt_idx];
    assign gnt_lock = req_lock[gnt_idx];

    always_comb begin
        req_ready    = '0;
        mem_adr      = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_dat_in   = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            mem_adr            = req_addr[int'(gnt_idx)*AW +: AW];
            mem_write_en       = gnt_we;
            mem_read_en        = ~gnt_we;
            mem_dat_in         = req_wdata[int'(gnt_idx)*DW +: DW];
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = lock_cnt_q;
        lock_err_d  = lock_err_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;

        if (gnt_vld) begin
            if (int'(gnt_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
            if (!gnt_we) begin
                rsp_valid_d[gnt_idx] = 1'b1;
                rsp_rdata_d          = mem_dat_out;
            end
        end

        case (state_q)
            ARB: begin
                if (gnt_vld && gnt_lock) begin
                    state_d    = LOCKED;
                    owner_d    = gnt_idx;
                    lock_cnt_d = '0;
                end
            end
            LOCKED: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (gnt_vld && !gnt_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CW'(LOCK_MAX - 1)) begin
                    // Timeout: this cycle's beat (if any) still completes.
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    lock_err_d = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign lock_err  = lock_err_q;

`ifdef DATA_MEMORY_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (gnt_vld && (grant_cnt_q[int'(gnt_idx)*16 +: 16] != 16'hFFFF)) begin
            grant_cnt_d[int'(gnt_idx)*16 +: 16] = grant_cnt_q[int'(gnt_idx)*16 +: 16] + 16'd1;
        end
        if (|(req_valid & ~req_ready) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
